// File: rtl/adbus_responder.sv
// Peripheral responder on a multiplexed 8085-style AD bus: latches the address on ALE,
// decodes a 4-register window and serves reads/writes with programmable wait states.
module adbus_responder #(
  parameter int                  DATASIZE = 8,
  parameter logic [DATASIZE-1:0] BASEADDR = 8'h40,
  parameter int                  WAITCNT  = 2,
  parameter int                  TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ale,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [DATASIZE-1:0]   ad_in,
  output logic [DATASIZE-1:0]   ad_out,
  output logic                  ad_oe,
  output logic                  ready,
  output logic [4*DATASIZE-1:0] regs,
  output logic                  err
);

  typedef enum logic [2:0] {IDLE, ADDR, WAITR, WAITW, READ, WRITE, IGNORE} state_t;

  localparam logic [7:0] WAIT_L = 8'(WAITCNT);
  localparam logic [7:0] TO_L   = 8'(TIMEOUT);

  state_t                       state, state_d;
  logic [DATASIZE-1:0]          addr, addr_d;
  logic [DATASIZE-1:0]          data_q, data_d;
  logic [DATASIZE-1:0]          ad_out_d;
  logic [3:0][DATASIZE-1:0]     rf, rf_d;
  logic [7:0]                   wcnt, wcnt_d;
  logic [7:0]                   tcnt, tcnt_d;
  logic                         ad_oe_d, ready_d, err_d;
  logic                         rd, wr, in_win;

  assign rd     = ~rd_n;
  assign wr     = ~wr_n;
  assign in_win = (addr[DATASIZE-1:2] == BASEADDR[DATASIZE-1:2]);
  assign regs   = rf;

  always_comb begin
    state_d  = state;
    addr_d   = addr;
    // Tracks the bus value of the most recent cycle the write strobe was low.
    data_d   = wr ? ad_in : data_q;
    rf_d     = rf;
    wcnt_d   = wcnt;
    tcnt_d   = '0;
    ad_out_d = ad_out;
    ad_oe_d  = ad_oe;
    ready_d  = ready;
    err_d    = err;

    if (ale && (state inside {WAITR, WAITW, READ, WRITE, IGNORE}))
      err_d = 1'b1;

    case (state)
      IDLE: begin
        ad_oe_d = 1'b0;
        ready_d = 1'b1;
        wcnt_d  = '0;
        if (ale) begin
          addr_d  = ad_in;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ale) begin
          addr_d = ad_in;
        end else if (rd && wr) begin
          err_d   = 1'b1;
          state_d = IGNORE;
        end else if ((rd || wr) && !in_win) begin
          state_d = IGNORE;
        end else if (rd || wr) begin
          wcnt_d = '0;
          if (WAIT_L == 8'd0) begin
            if (rd) begin
              state_d  = READ;
              ad_oe_d  = 1'b1;
              ad_out_d = rf[addr[1:0]];
            end else begin
              state_d = WRITE;
            end
          end else begin
            ready_d = 1'b0;
            state_d = rd ? WAITR : WAITW;
          end
        end else if (tcnt + 8'd1 >= TO_L) begin
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt + 8'd1;
        end
      end
      WAITR: begin
        if (!rd) begin
          ready_d = 1'b1;
          wcnt_d  = '0;
          state_d = IDLE;
        end else if (wcnt + 8'd1 >= WAIT_L) begin
          ready_d  = 1'b1;
          wcnt_d   = '0;
          state_d  = READ;
          ad_oe_d  = 1'b1;
          ad_out_d = rf[addr[1:0]];
        end else begin
          wcnt_d  = wcnt + 8'd1;
          ready_d = 1'b0;
        end
      end
      WAITW: begin
        // An early strobe release still commits the last sampled data.
        if (!wr) begin
          rf_d[addr[1:0]] = data_q;
          ready_d         = 1'b1;
          wcnt_d          = '0;
          state_d         = IDLE;
        end else if (wcnt + 8'd1 >= WAIT_L) begin
          ready_d = 1'b1;
          wcnt_d  = '0;
          state_d = WRITE;
        end else begin
          wcnt_d  = wcnt + 8'd1;
          ready_d = 1'b0;
        end
      end
      READ: begin
        if (!rd) begin
          ad_oe_d  = 1'b0;
          ad_out_d = '0;
          state_d  = IDLE;
        end else begin
          ad_out_d = rf[addr[1:0]];
        end
      end
      WRITE: begin
        if (!wr) begin
          rf_d[addr[1:0]] = data_q;
          state_d         = IDLE;
        end
      end
      IGNORE: begin
        if (!rd && !wr)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      data_q <= '0;
      rf     <= '0;
      wcnt   <= '0;
      tcnt   <= '0;
      ad_out <= '0;
      ad_oe  <= 1'b0;
      ready  <= 1'b1;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      addr   <= addr_d;
      data_q <= data_d;
      rf     <= rf_d;
      wcnt   <= wcnt_d;
      tcnt   <= tcnt_d;
      ad_out <= ad_out_d;
      ad_oe  <= ad_oe_d;
      ready  <= ready_d;
      err    <= err_d;
    end
  end

  oe_only_in_read: assert property (@(posedge clk) disable iff (rst) ad_oe |-> (state == READ));

endmodule

// File: tb/tb_adbus_responder.sv
// Directed bench for adbus_responder: per-transaction rules fill a per-cycle expectation
// table that one negedge process compares against the DUT, plus literal spot checks.
module tb_adbus_responder;
  localparam int W  = 2;
  localparam int TO = 15;
  localparam int N  = 2048;

  logic        clk = 1'b0;
  logic        rst, ale, rd_n, wr_n;
  logic [7:0]  ad_in, ad_out;
  logic        ad_oe, ready, err;
  logic [31:0] regs;

  adbus_responder #(.DATASIZE(8), .BASEADDR(8'h40), .WAITCNT(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ready(ready), .regs(regs), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  bit          exp_oe  [N];
  bit          exp_rdy [N];
  bit          exp_err [N];
  logic [7:0]  exp_out [N];
  logic [31:0] exp_regs[N];

  bit         chk_en = 1'b0;
  int         oe_cnt, low_cnt;
  logic [7:0] last_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst && cyc < N) begin
      check("ad_oe", 32'(ad_oe), 32'(exp_oe[cyc]));
      check("ready", 32'(ready), 32'(exp_rdy[cyc]));
      check("regs",  regs,       exp_regs[cyc]);
      check("err",   32'(err),   32'(exp_err[cyc]));
      if (exp_oe[cyc]) check("ad_out", 32'(ad_out), 32'(exp_out[cyc]));
      if (ad_oe) begin
        oe_cnt++;
        last_out = ad_out;
      end
      if (!ready) low_cnt++;
    end
  end

  function automatic void regs_from(input int c, input int idx, input logic [7:0] v);
    for (int i = c; i < N; i++) exp_regs[i][idx*8 +: 8] = v;
  endfunction

  function automatic void err_from(input int c);
    for (int i = c; i < N; i++) exp_err[i] = 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 read, 1 write, 2 both strobes. Strobe low for len cycles after gap idle
  // cycles following ALE; ale_off >= 0 pulses ALE that many cycles into the strobe.
  task automatic txn(input int kind, input logic [7:0] a, input logic [7:0] d,
                     input int gap, input int len, input int ale_off);
    int n0, s, r, idx;
    bit live, inwin;
    n0 = cyc;
    s = n0 + 1 + gap;
    r = s + len;
    idx = int'(a[1:0]);
    live = (gap < TO);
    inwin = (a[7:2] == 6'h10);
    oe_cnt = 0;
    low_cnt = 0;
    last_out = 8'h00;
    if (live) begin
      if (kind == 2) begin
        err_from(s + 1);
      end else if (inwin) begin
        for (int t = s + 1; t <= s + W && t <= r; t++) exp_rdy[t] = 1'b0;
        if (kind == 1) begin
          regs_from(r + 1, idx, d);
        end else if (r > s + W) begin
          for (int t = s + W + 1; t <= r; t++) begin
            exp_oe[t]  = 1'b1;
            exp_out[t] = exp_regs[s][idx*8 +: 8];
          end
        end
      end
      if (ale_off >= 0) err_from(s + ale_off + 1);
    end
    for (int t = n0; t <= r + 2; t++) begin
      ale = (t == n0) || (ale_off >= 0 && t == s + ale_off);
      if (t == n0) ad_in = a;
      else if (kind == 1 && t >= s && t < r) ad_in = (t == r - 1) ? d : ~d;
      else if (t >= r) ad_in = 8'h5A;
      rd_n = !(t >= s && t < r && kind != 1);
      wr_n = !(t >= s && t < r && kind != 0);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_oe[i] = 1'b0; exp_rdy[i] = 1'b1; exp_err[i] = 1'b0;
      exp_out[i] = 8'h00; exp_regs[i] = 32'h0;
    end
    rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; ad_in = 8'h00;
    repeat (3) step();
    check("reset ad_oe", 32'(ad_oe), 32'd0);
    check("reset ready", 32'(ready), 32'd1);
    check("reset regs",  regs,       32'h0);
    check("reset err",   32'(err),   32'd0);
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    step();

    txn(1, 8'h41, 8'hA5, 0, 4, -1);
    check("write ready-low cycles", 32'(low_cnt), 32'd2);
    check("write ad_oe cycles", 32'(oe_cnt), 32'd0);
    check("write reg1", 32'(regs[15:8]), 32'hA5);
    check("write other regs", regs & 32'hFFFF00FF, 32'h0);

    txn(0, 8'h41, 8'h00, 0, 5, -1);
    check("read ad_oe cycles", 32'(oe_cnt), 32'd3);
    check("read data", 32'(last_out), 32'hA5);
    check("read ready-low cycles", 32'(low_cnt), 32'd2);

    txn(0, 8'h50, 8'h00, 0, 3, -1);
    check("outside ad_oe cycles", 32'(oe_cnt), 32'd0);
    check("outside ready-low cycles", 32'(low_cnt), 32'd0);
    check("outside regs", regs, 32'h0000A500);

    txn(2, 8'h42, 8'h00, 0, 3, -1);
    check("both strobes err", 32'(err), 32'd1);
    check("both strobes regs", regs, 32'h0000A500);
    txn(1, 8'h43, 8'h3C, 1, 3, -1);
    check("write after err regs", regs, 32'h3C00A500);
    check("err sticky", 32'(err), 32'd1);

    txn(0, 8'h41, 8'h00, 14, 4, -1);
    check("late strobe ad_oe cycles", 32'(oe_cnt), 32'd2);
    check("late strobe data", 32'(last_out), 32'hA5);
    txn(0, 8'h41, 8'h00, 15, 4, -1);
    check("timed-out ad_oe cycles", 32'(oe_cnt), 32'd0);
    check("timed-out ready-low cycles", 32'(low_cnt), 32'd0);
    txn(0, 8'h40, 8'h00, 20, 3, -1);
    check("no-ale read ad_oe cycles", 32'(oe_cnt), 32'd0);

    txn(1, 8'h40, 8'h77, 0, 1, -1);
    check("early-release ready-low cycles", 32'(low_cnt), 32'd1);
    check("early-release reg0", 32'(regs[7:0]), 32'h77);

    txn(0, 8'h42, 8'h00, 0, 2, -1);
    check("aborted read ad_oe cycles", 32'(oe_cnt), 32'd0);
    check("aborted read ready-low cycles", 32'(low_cnt), 32'd2);
    txn(0, 8'h43, 8'h00, 0, 3, -1);
    check("short read ad_oe cycles", 32'(oe_cnt), 32'd1);
    check("short read data", 32'(last_out), 32'h3C);

    chk_en = 1'b0;
    ale = 1'b1; ad_in = 8'h41;
    step();
    ale = 1'b0; rd_n = 1'b0;
    repeat (3) step();
    check("pre-reset ad_oe", 32'(ad_oe), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async reset ad_oe", 32'(ad_oe), 32'd0);
    check("async reset ready", 32'(ready), 32'd1);
    check("async reset regs",  regs,       32'h0);
    check("async reset err",   32'(err),   32'd0);
    rd_n = 1'b1;
    step();
    rst = 1'b0;
    for (int i = cyc; i < N; i++) begin
      exp_regs[i] = 32'h0; exp_err[i] = 1'b0; exp_oe[i] = 1'b0; exp_rdy[i] = 1'b1;
    end
    step();
    chk_en = 1'b1;

    txn(0, 8'h41, 8'h00, 0, 5, 3);
    check("ale-in-read ad_oe cycles", 32'(oe_cnt), 32'd3);
    check("ale-in-read data", 32'(last_out), 32'h00);
    check("ale-in-read err", 32'(err), 32'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
